// File: rtl/level_sequencer.sv
// Game flow sequencer: IDLE/PLAY/DYING/LEVEL_DONE/GAME_OVER with bomb fuse timing on frame ticks.
// All outputs registered, updating on the edge that consumes the input; no backpressure, inputs sampled every cycle.
module level_sequencer #(
  parameter int BOMB_STEP    = 30,
  parameter int DYING_FRAMES = 60,
  parameter int DONE_FRAMES  = 60,
  parameter int NUM_LEVELS   = 3,
  parameter int START_LIVES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       bomb_key,
  input  logic       death,
  input  logic       exit_reached,
  input  logic [9:0] char_pos_x,
  input  logic [9:0] char_pos_y,
  output logic       active,
  output logic [3:0] part_en,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic [3:0] b_cnt,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic       game_over,
  output logic       win
);

  localparam int MAXF_A = (DYING_FRAMES > DONE_FRAMES) ? DYING_FRAMES : DONE_FRAMES;
  localparam int MAXF   = (MAXF_A > BOMB_STEP) ? MAXF_A : BOMB_STEP;
  localparam int CW     = $clog2(MAXF + 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_DYING, S_DONE, S_OVER} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_start_q, r_bomb_q, r_exit_q;
  logic [1:0]      r_part, w_part_nxt;
  logic [1:0]      r_level, w_level_nxt;
  logic [1:0]      r_lives, w_lives_nxt;
  logic [3:0]      r_b_cnt, w_b_cnt_nxt;
  logic [9:0]      r_bomb_x, w_bomb_x_nxt;
  logic [9:0]      r_bomb_y, w_bomb_y_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_active, r_game_over, r_win;
  logic [3:0]      r_part_en;
  logic            w_active_nxt, w_game_over_nxt, w_win_nxt;
  logic [3:0]      w_part_en_nxt;
  logic            w_start_rise, w_bomb_rise, w_exit_rise;
  logic            w_dying_end, w_done_end, w_step_end;

  assign w_start_rise = start_key & ~r_start_q;
  assign w_bomb_rise  = bomb_key & ~r_bomb_q;
  assign w_exit_rise  = exit_reached & ~r_exit_q;
  assign w_dying_end  = frame_tick && (r_cnt == CW'(DYING_FRAMES - 1));
  assign w_done_end   = frame_tick && (r_cnt == CW'(DONE_FRAMES - 1));
  assign w_step_end   = r_cnt == CW'(BOMB_STEP - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_rise) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (death)                                 w_state_nxt = S_DYING;
        else if (w_exit_rise && (r_part == 2'd3))  w_state_nxt = S_DONE;
      end
      S_DYING: if (w_dying_end) w_state_nxt = (r_lives == 2'd0) ? S_OVER : S_PLAY;
      S_DONE:  if (w_done_end)  w_state_nxt = (r_level == 2'(NUM_LEVELS - 1)) ? S_OVER : S_PLAY;
      S_OVER:  if (w_start_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; the frame counter doubles as bomb step counter in PLAY.
  always_comb begin
    w_part_nxt   = r_part;
    w_level_nxt  = r_level;
    w_lives_nxt  = r_lives;
    w_b_cnt_nxt  = r_b_cnt;
    w_bomb_x_nxt = r_bomb_x;
    w_bomb_y_nxt = r_bomb_y;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: if (w_start_rise) begin
        w_level_nxt = 2'd0;
        w_part_nxt  = 2'd0;
        w_lives_nxt = 2'(START_LIVES);
        w_b_cnt_nxt = 4'd0;
      end
      S_PLAY: begin
        if (death) begin
          w_lives_nxt = r_lives - 2'd1;
        end else if (w_exit_rise) begin
          w_b_cnt_nxt = 4'd0;
          w_cnt_nxt   = '0;
          if (r_part != 2'd3) w_part_nxt = r_part + 2'd1;
        end else if (w_bomb_rise && (r_b_cnt == 4'd0)) begin
          w_bomb_x_nxt = char_pos_x;
          w_bomb_y_nxt = char_pos_y;
          w_b_cnt_nxt  = 4'd1;
          w_cnt_nxt    = '0;
        end else if ((r_b_cnt != 4'd0) && frame_tick) begin
          if (w_step_end) begin
            w_cnt_nxt   = '0;
            w_b_cnt_nxt = (r_b_cnt == 4'd3) ? 4'd0 : r_b_cnt + 4'd1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_DYING: if (frame_tick) w_cnt_nxt = r_cnt + CW'(1);
      S_DONE: begin
        if (frame_tick) w_cnt_nxt = r_cnt + CW'(1);
        if (w_done_end && (r_level != 2'(NUM_LEVELS - 1))) begin
          w_level_nxt = r_level + 2'd1;
          w_part_nxt  = 2'd0;
        end
      end
      default: ;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    if (w_state_nxt != S_PLAY)  w_b_cnt_nxt = 4'd0;
  end

  always_comb begin
    w_active_nxt    = (w_state_nxt == S_PLAY);
    w_part_en_nxt   = ((w_state_nxt == S_PLAY) || (w_state_nxt == S_DYING)) ? (4'b0001 << w_part_nxt) : 4'b0000;
    w_game_over_nxt = (w_state_nxt == S_OVER);
    // Win is decided by the state we leave into GAME_OVER from, then held.
    w_win_nxt       = (w_state_nxt == S_OVER) && ((r_state == S_OVER) ? r_win : (r_state == S_DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q   <= 1'b1;
      r_bomb_q    <= 1'b1;
      r_exit_q    <= 1'b1;
      r_part      <= 2'd0;
      r_level     <= 2'd0;
      r_lives     <= 2'd0;
      r_b_cnt     <= 4'd0;
      r_bomb_x    <= 10'd0;
      r_bomb_y    <= 10'd0;
      r_cnt       <= '0;
      r_active    <= 1'b0;
      r_part_en   <= 4'd0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_start_q   <= start_key;
      r_bomb_q    <= bomb_key;
      r_exit_q    <= exit_reached;
      r_part      <= w_part_nxt;
      r_level     <= w_level_nxt;
      r_lives     <= w_lives_nxt;
      r_b_cnt     <= w_b_cnt_nxt;
      r_bomb_x    <= w_bomb_x_nxt;
      r_bomb_y    <= w_bomb_y_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_part_en   <= w_part_en_nxt;
      r_game_over <= w_game_over_nxt;
      r_win       <= w_win_nxt;
    end
  end

  assign active     = r_active;
  assign part_en    = r_part_en;
  assign level      = r_level;
  assign lives      = r_lives;
  assign b_cnt      = r_b_cnt;
  assign bomb_pos_x = r_bomb_x;
  assign bomb_pos_y = r_bomb_y;
  assign game_over  = r_game_over;
  assign win        = r_win;

endmodule
